// File: rtl/sb_defs.sv
// Shared widths and helpers for the store buffer.
package sb_defs;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;
  localparam int SB_MW = SB_DW / 8;

  function automatic int sb_mw(input int dw);
    return dw / 8;
  endfunction

  function automatic int sb_waw(input int aw);
    return aw - 2;
  endfunction

  function automatic int sb_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_ptrs.sv
// Head/tail/count bookkeeping for the store FIFO.
module store_buffer_ptrs
  import sb_defs::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = sb_log2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  output logic [PW-1:0] head_o,
  output logic [PW-1:0] tail_o,
  output logic [PW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i)  head_d = head_q + 1'b1;
    if (push_i) tail_d = tail_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between the memory stage and data memory,
// with load-after-store hazard detection on word addresses.
module store_buffer
  import sb_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [AW-1:0]    DataAdr,
  input  logic [DW-1:0]    WriteData,
  input  logic [DW/8-1:0]  WriteMask,
  input  logic             MemRead,
  output logic             StallM,
  output logic             Empty,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic [DW/8-1:0]  mem_wmask,
  input  logic             mem_ready
);

  localparam int MW  = sb_mw(DW);
  localparam int WAW = sb_waw(AW);
  localparam int PW  = sb_log2(DEPTH);

  logic [WAW-1:0]   addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [MW-1:0]    mask_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          full, empty;
  logic          push, pop, hit;
  logic          unused_lo;

  store_buffer_ptrs #(.DEPTH(DEPTH)) u_ptrs (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .head_o  (head),
    .tail_o  (tail),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Byte offset within a word never matters for the hazard check.
  assign unused_lo = ^{DataAdr[1:0], count};

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && addr_q[i] == DataAdr[AW-1:2]) hit = 1'b1;
  end

  assign StallM = (MemWrite && full) || (MemRead && hit);
  assign push   = MemWrite && !full && !StallM;
  assign mem_we = vld_q[head];
  assign pop    = mem_we && mem_ready;

  always_comb begin
    vld_d = vld_q;
    if (pop)  vld_d[head] = 1'b0;
    if (push) vld_d[tail] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= DataAdr[AW-1:2];
      data_q[tail] <= WriteData;
      mask_q[tail] <= WriteMask;
    end
  end

  assign mem_addr  = {addr_q[head], 2'b00};
  assign mem_wdata = data_q[head];
  assign mem_wmask = mask_q[head];
  assign Empty     = empty;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: ordering, stalls, hazards, reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [3:0]  WriteMask;
  logic        MemRead;
  logic        StallM;
  logic        Empty;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;

  int tests = 0;
  int fails = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_mask[$];

  logic        hold_q = 1'b0;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_mask;

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .WriteMask (WriteMask),
    .MemRead   (MemRead),
    .StallM    (StallM),
    .Empty     (Empty),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Pop recorder and hold-stability check; inputs change only at posedge+1.
  always @(negedge clk) begin
    if (hold_q === 1'b1) begin
      tests++;
      if (mem_we !== 1'b1 || mem_addr !== h_addr ||
          mem_wdata !== h_data || mem_wmask !== h_mask) begin
        fails++;
        $display("FAIL stable: got we=%b a=%h d=%h m=%h want a=%h d=%h m=%h",
                 mem_we, mem_addr, mem_wdata, mem_wmask,
                 h_addr, h_data, h_mask);
      end
    end
    hold_q = (reset === 1'b1) && (mem_we === 1'b1) && (mem_ready === 1'b0);
    h_addr = mem_addr;
    h_data = mem_wdata;
    h_mask = mem_wmask;
    if (reset === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_wdata);
      q_mask.push_back(mem_wmask);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_mask.delete();
  endtask

  function automatic logic ready_of(input int mode, input int cyc);
    if (mode == 1) return cyc[0];
    if (mode == 2) return (cyc % 3) != 0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] mask_of(input int i);
    return 4'(1 << (i % 4));
  endfunction

  // Issue n stores, honouring StallM, then drain; returns cycles used.
  task automatic drive_stores(input int n, input logic [31:0] base,
                              input logic [31:0] dbase, input int mode,
                              output int cyc);
    int  i;
    logic st;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 200) begin
      MemWrite  = 1'b1;
      DataAdr   = base + 32'(4 * i);
      WriteData = dbase + 32'(i);
      WriteMask = mask_of(i);
      mem_ready = ready_of(mode, cyc);
      @(negedge clk);
      st = StallM;
      next_cycle();
      if (!st) i++;
      cyc++;
    end
    MemWrite = 1'b0;
    while (cyc < 200) begin
      mem_ready = ready_of(mode, cyc);
      @(negedge clk);
      if (Empty) break;
      next_cycle();
      cyc++;
    end
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MemWrite = 1'b0;
    MemRead = 1'b0;
    DataAdr = '0;
    WriteData = '0;
    WriteMask = '0;
    mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL reset_we: got %b want 0", mem_we);
    end
    tests++;
    if (Empty !== 1'b1) begin
      fails++; $display("FAIL reset_empty: got %b want 1", Empty);
    end
    tests++;
    if (StallM !== 1'b0) begin
      fails++; $display("FAIL reset_stall: got %b want 0", StallM);
    end
    next_cycle();
  endtask

  task automatic test_single();
    clear_q();
    MemWrite = 1'b1;
    DataAdr = 32'h64;
    WriteData = 32'h07;
    WriteMask = 4'hF;
    mem_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (StallM !== 1'b0) begin
      fails++; $display("FAIL single_stall: got %b want 0", StallM);
    end
    next_cycle();
    MemWrite = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h64 ||
        mem_wdata !== 32'h07 || mem_wmask !== 4'hF) begin
      fails++;
      $display("FAIL single_port: got we=%b a=%h d=%h m=%h want 1 64 07 f",
               mem_we, mem_addr, mem_wdata, mem_wmask);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (Empty !== 1'b1) begin
      fails++; $display("FAIL single_empty: got %b want 1", Empty);
    end
    tests++;
    if (q_addr.size() != 1) begin
      fails++; $display("FAIL single_pops: got %0d want 1", q_addr.size());
    end
    next_cycle();
  endtask

  task automatic test_full();
    logic [31:0] ea;
    int k;
    clear_q();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      MemWrite = 1'b1;
      DataAdr = 32'h60 + 32'(4 * i);
      WriteData = 32'h100 + 32'(i);
      WriteMask = 4'hF;
      @(negedge clk);
      tests++;
      if (StallM !== (i == 4)) begin
        fails++;
        $display("FAIL full_stall%0d: got %b want %b", i, StallM, i == 4);
      end
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (StallM !== 1'b1 || mem_addr !== 32'h60) begin
      fails++;
      $display("FAIL full_drain_stall: got st=%b a=%h want 1 60",
               StallM, mem_addr);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (StallM !== 1'b0) begin
      fails++; $display("FAIL full_accept: got %b want 0", StallM);
    end
    next_cycle();
    MemWrite = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (Empty) break;
      next_cycle();
      k++;
    end
    tests++;
    if (k >= 20) begin
      fails++; $display("FAIL full_timeout: got %0d cycles want <20", k);
    end
    next_cycle();
    tests++;
    if (q_addr.size() != 5) begin
      fails++; $display("FAIL full_count: got %0d want 5", q_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        ea = 32'h60 + 32'(4 * i);
        tests++;
        if (q_addr[i] !== ea || q_data[i] !== 32'h100 + 32'(i)) begin
          fails++;
          $display("FAIL full_order%0d: got %h/%h want %h/%h", i,
                   q_addr[i], q_data[i], ea, 32'h100 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_raw();
    clear_q();
    mem_ready = 1'b0;
    MemWrite = 1'b1;
    DataAdr = 32'h64;
    WriteData = 32'hAA;
    WriteMask = 4'h3;
    next_cycle();
    MemWrite = 1'b0;
    MemRead = 1'b1;
    DataAdr = 32'h66;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (StallM !== 1'b1) begin
        fails++; $display("FAIL raw_hit%0d: got %b want 1", i, StallM);
      end
      next_cycle();
    end
    DataAdr = 32'h80;
    @(negedge clk);
    tests++;
    if (StallM !== 1'b0) begin
      fails++; $display("FAIL raw_miss: got %b want 0", StallM);
    end
    next_cycle();
    DataAdr = 32'h66;
    mem_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (StallM !== 1'b1) begin
      fails++; $display("FAIL raw_drain: got %b want 1", StallM);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (StallM !== 1'b0 || Empty !== 1'b1) begin
      fails++;
      $display("FAIL raw_release: got st=%b e=%b want 0 1", StallM, Empty);
    end
    tests++;
    if (q_addr.size() != 1 || q_addr[0] !== 32'h64 || q_mask[0] !== 4'h3) begin
      fails++;
      $display("FAIL raw_pop: got n=%0d want one pop of 64 mask 3",
               q_addr.size());
    end
    next_cycle();
    MemRead = 1'b0;
  endtask

  task automatic test_order(input string nm, input int n,
                            input logic [31:0] base, input logic [31:0] dbase,
                            input int mode);
    int cyc;
    clear_q();
    drive_stores(n, base, dbase, mode, cyc);
    tests++;
    if (cyc >= 200) begin
      fails++; $display("FAIL %s_timeout: got %0d cycles want <200", nm, cyc);
    end
    tests++;
    if (q_addr.size() != n) begin
      fails++;
      $display("FAIL %s_count: got %0d want %0d", nm, q_addr.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        tests++;
        if (q_addr[i] !== base + 32'(4 * i) ||
            q_data[i] !== dbase + 32'(i) ||
            q_mask[i] !== mask_of(i)) begin
          fails++;
          $display("FAIL %s_pop%0d: got %h/%h/%h want %h/%h/%h", nm, i,
                   q_addr[i], q_data[i], q_mask[i],
                   base + 32'(4 * i), dbase + 32'(i), mask_of(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      MemWrite = 1'b1;
      DataAdr = 32'h300 + 32'(4 * i);
      WriteData = 32'hE0 + 32'(i);
      WriteMask = 4'hF;
      next_cycle();
    end
    MemWrite = 1'b0;
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b0 || Empty !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_state: got we=%b e=%b want 0 1", mem_we, Empty);
    end
    next_cycle();
    test_order("rstmid", 1, 32'h64, 32'h55, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_raw();
    test_order("wrap", 10, 32'h200, 32'hD000_0000, 2);
    test_reset_mid();
    test_order("bp", 6, 32'h400, 32'hB0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer between the pipeline's memory stage and data memory.
- Captures stores (MemWrite/DataAdr/WriteData) into an in-order FIFO and drains them to a data memory port under a valid/ready handshake.
- Stalls the memory stage when the FIFO is full, or when a load hits a word still pending in the buffer (RAW on memory).
- Lets the pipeline retire stores without waiting on slow memory.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..16.
- AW, 32, address width.
- DW, 32, data width; byte mask width is DW/8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: reset==0 at a rising clk edge clears the block.
- MemWrite  in  1  store request from the memory stage.
- DataAdr  in  AW  store/load byte address from the memory stage.
- WriteData  in  DW  store data.
- WriteMask  in  DW/8  byte enables of the store.
- MemRead  in  1  load request from the memory stage; same DataAdr.
- StallM  out  1  hold the memory stage this cycle.
- Empty  out  1  no pending entries.
- mem_we  out  1  head entry valid; write request to data memory.
- mem_addr  out  AW  head entry address, word aligned (low 2 bits forced to 0).
- mem_wdata  out  DW  head entry data.
- mem_wmask  out  DW/8  head entry byte mask.
- mem_ready  in  1  memory accepts the head entry this cycle.

Behaviour:
- Storage: DEPTH entries {word addr AW-2, data, mask, valid}; head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Reset (reset==0 at an edge): pointers=0, count=0, all valid=0.
  - Outputs after reset: mem_we=0, Empty=1, StallM=0 (unless MemWrite with full, impossible at count 0).
  - A reset mid-drain discards all pending stores; an in-flight mem_we is simply dropped. Memory must not rely on mem_we staying high after reset.
- Full is defined as count==DEPTH.
- Enqueue: MemWrite && !full && !StallM at an edge writes the entry at tail and advances tail.
- Dequeue: mem_we && mem_ready at an edge invalidates the head entry and advances head.
- Simultaneous enqueue and dequeue: both occur and count is unchanged.
- Full buffer with a drain in the same cycle: StallM=1 anyway and the store is not taken. There is no same-cycle bypass; the store is accepted the next cycle.
- StallM is combinational: (MemWrite && full) || (MemRead && hit).
  - hit means some valid entry has word addr == DataAdr[AW-1:2]. The compare ignores the mask.
  - The stall holds until that entry drains.
- mem_we/mem_addr/mem_wdata/mem_wmask are driven from registered head state only; there is no combinational path from pipeline inputs to the memory port.
- Latency: a store accepted at edge t into an empty buffer gives mem_we=1 in the cycle after edge t.
- mem_* fields are held stable while mem_we=1 && mem_ready=0.
- Strict FIFO order; stores are never merged or reordered.
- Empty = (count==0). It is the only ordering barrier the pipeline needs for fence-like waits.
- MemWrite and MemRead both high in the same cycle is illegal: the stall follows the formula above and the store is enqueued only if StallM==0.

Decomposition:
- Shared package/header sb_defs:
  - Entry field widths derived from AW/DW.
  - Mask width constant.
  - Helper function for log2(DEPTH).
- One sub-module, store_buffer_ptrs: head/tail/count registers, full/empty flags, push/pop logic.
- Entry storage, address match and port muxing stay in store_buffer.

Test Plan:
- Reset then a single store DataAdr=0x64, WriteData=0x07, mask=0xF, mem_ready=1:
  - Next cycle: mem_we=1, mem_addr=0x64, mem_wdata=0x07.
  - Cycle after: Empty=1.
- mem_ready=0, five stores 0x60,0x64,0x68,0x6C,0x70 (DEPTH=4):
  - First four accepted.
  - Fifth sees StallM=1.
  - Raise mem_ready: drains in order 0x60..0x6C; fifth accepted after the first pop and emitted last.
- Pending store at 0x64 (mem_ready=0), load DataAdr=0x66:
  - StallM=1 until the 0x64 entry drains.
  - Load at 0x80 gives StallM=0.
- Full buffer, mem_ready=1 with MemWrite:
  - Cycle 1: StallM=1, count goes 4 to 3.
  - Next cycle: store accepted, count back to 4.
  - Pointers wrap with correct order over 10 stores.
- Reset (reset=0) while 3 entries are pending:
  - Next cycle: mem_we=0, Empty=1.
  - A subsequent store to 0x64 drains with the correct data.
- Backpressure: mem_ready toggles 0/1 every cycle across 6 stores:
  - mem_* stable whenever mem_ready=0.
  - Each entry emitted exactly once.
